// File: rtl/awg_cmd_pkg.sv
// Shared constants and decode helpers for the AWG UART command parser.
package awg_cmd_pkg;

   // ASCII codes recognised by the parser
   localparam logic [7:0] ASC_F_UP = 8'h46;
   localparam logic [7:0] ASC_F_LO = 8'h66;
   localparam logic [7:0] ASC_A_UP = 8'h41;
   localparam logic [7:0] ASC_A_LO = 8'h61;
   localparam logic [7:0] ASC_P_UP = 8'h50;
   localparam logic [7:0] ASC_P_LO = 8'h70;
   localparam logic [7:0] ASC_W_UP = 8'h57;
   localparam logic [7:0] ASC_W_LO = 8'h77;
   localparam logic [7:0] ASC_0    = 8'h30;
   localparam logic [7:0] ASC_9    = 8'h39;
   localparam logic [7:0] ASC_CR   = 8'h0D;
   localparam logic [7:0] ASC_LF   = 8'h0A;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DIGITS  = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   // Command target; the value doubles as the bit index into upd
   typedef enum logic [1:0] {
      TGT_F = 2'd0,
      TGT_A = 2'd1,
      TGT_P = 2'd2,
      TGT_W = 2'd3
   } tgt_e;

   // err_code values
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_RANGE   = 2'd1;
   localparam logic [1:0] ERR_FORMAT  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= ASC_0) && (c <= ASC_9);
   endfunction

   function automatic logic is_term(input logic [7:0] c);
      return (c == ASC_CR) || (c == ASC_LF);
   endfunction

   function automatic logic is_letter(input logic [7:0] c);
      return (c == ASC_F_UP) || (c == ASC_F_LO) || (c == ASC_A_UP) || (c == ASC_A_LO) ||
             (c == ASC_P_UP) || (c == ASC_P_LO) || (c == ASC_W_UP) || (c == ASC_W_LO);
   endfunction

   function automatic tgt_e letter_tgt(input logic [7:0] c);
      tgt_e t;
      case (c)
         ASC_A_UP, ASC_A_LO: t = TGT_A;
         ASC_P_UP, ASC_P_LO: t = TGT_P;
         ASC_W_UP, ASC_W_LO: t = TGT_W;
         default:            t = TGT_F;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for an asynchronous strobe followed by a rising-edge
// detector. pulse_out is high for one clk cycle, two edges after async_in rises.
module strobe_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // next-state of the synchroniser chain and edge-detect history
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // synchroniser and history flops, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign pulse_out = sync_q & ~prev_q;

endmodule

// File: rtl/awg_cmd_parser.sv
// UART command parser for the AWG: decodes F/A/P/W<digits><CR|LF>, range-checks
// the value against the target width and commits it to registered outputs.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | waiting for a command letter; everything else ignored
//   ST_DIGITS  | letter seen; accumulating decimal digits until terminator
//   ST_DISCARD | malformed command; swallow bytes until terminator, then err
module awg_cmd_parser
   import awg_cmd_pkg::*;
#(
   parameter int FREQ_W      = 12,
   parameter int AMP_W       = 3,
   parameter int PHASE_W     = 8,
   parameter int STATE_W     = 3,
   parameter int MAX_DIGITS  = 5,
   parameter int TIMEOUT_CYC = 50_000_000,
   parameter int RST_FREQ    = 1,
   parameter int RST_AMP     = 2,
   parameter int RST_PHASE   = 50,
   parameter int RST_STATE   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         cmd,
   input  logic               rd,
   output logic [STATE_W-1:0] state,
   output logic [FREQ_W-1:0]  state_freq,
   output logic [AMP_W-1:0]   state_amp,
   output logic [PHASE_W-1:0] state_phase,
   output logic [3:0]         upd,
   output logic               err,
   output logic [1:0]         err_code
);

   localparam int ACC_W = $clog2(10 ** MAX_DIGITS);
   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

   logic               byte_vld;
   logic               timeout;
   logic               in_range;
   logic [ACC_W-1:0]   acc_next;

   logic [1:0]         fsm_q, fsm_d;
   tgt_e               tgt_q, tgt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [1:0]         disc_code_q, disc_code_d;
   logic [FREQ_W-1:0]  state_freq_q, state_freq_d;
   logic [AMP_W-1:0]   state_amp_q, state_amp_d;
   logic [PHASE_W-1:0] state_phase_q, state_phase_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic [3:0]         upd_q, upd_d;
   logic               err_q, err_d;
   logic [1:0]         err_code_q, err_code_d;

   strobe_sync u_rd_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_in  (rd),
      .pulse_out (byte_vld)
   );

   // decimal shift-in and range test of the accumulated value for the current target
   always_comb begin
      acc_next = (acc_q << 3) + (acc_q << 1) + ACC_W'(cmd[3:0]);
      in_range = 1'b0;
      case (tgt_q)
         TGT_F:   in_range = (acc_q >> FREQ_W) == '0;
         TGT_A:   in_range = (acc_q >> AMP_W) == '0;
         TGT_P:   in_range = (acc_q >> PHASE_W) == '0;
         TGT_W:   in_range = (acc_q >> STATE_W) == '0;
         default: in_range = 1'b0;
      endcase
   end

   // a byte arriving on the expiry cycle wins over the timeout
   assign timeout = (fsm_q != ST_IDLE) && (tmr_q == '0) && !byte_vld;

   // parser FSM, inter-byte timer and output commit
   always_comb begin
      fsm_d         = fsm_q;
      tgt_d         = tgt_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      disc_code_d   = disc_code_q;
      state_freq_d  = state_freq_q;
      state_amp_d   = state_amp_q;
      state_phase_d = state_phase_q;
      state_d       = state_q;
      upd_d         = 4'b0000;
      err_d         = 1'b0;
      err_code_d    = err_code_q;

      if (fsm_q == ST_IDLE || byte_vld) begin
         tmr_d = TMR_LOAD;
      end else if (tmr_q != '0) begin
         tmr_d = tmr_q - 1'b1;
      end else begin
         tmr_d = tmr_q;
      end

      if (timeout) begin
         fsm_d      = ST_IDLE;
         err_d      = 1'b1;
         err_code_d = ERR_TIMEOUT;
      end else if (byte_vld) begin
         case (fsm_q)
            ST_IDLE: begin
               if (is_letter(cmd)) begin
                  tgt_d = letter_tgt(cmd);
                  acc_d = '0;
                  cnt_d = '0;
                  fsm_d = ST_DIGITS;
               end
            end
            ST_DIGITS: begin
               if (is_digit(cmd)) begin
                  if (cnt_q == CNT_W'(MAX_DIGITS)) begin
                     fsm_d       = ST_DISCARD;
                     disc_code_d = ERR_FORMAT;
                  end else begin
                     acc_d = acc_next;
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (is_term(cmd)) begin
                  fsm_d = ST_IDLE;
                  if (cnt_q == '0) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_FORMAT;
                  end else if (!in_range) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_RANGE;
                  end else begin
                     upd_d[tgt_q] = 1'b1;
                     case (tgt_q)
                        TGT_F:   state_freq_d  = FREQ_W'(acc_q);
                        TGT_A:   state_amp_d   = AMP_W'(acc_q);
                        TGT_P:   state_phase_d = PHASE_W'(acc_q);
                        default: state_d       = STATE_W'(acc_q);
                     endcase
                  end
               end else if (is_letter(cmd)) begin
                  tgt_d = letter_tgt(cmd);
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  fsm_d       = ST_DISCARD;
                  disc_code_d = ERR_FORMAT;
               end
            end
            ST_DISCARD: begin
               if (is_term(cmd)) begin
                  fsm_d      = ST_IDLE;
                  err_d      = 1'b1;
                  err_code_d = disc_code_q;
               end
            end
            default: fsm_d = ST_IDLE;
         endcase
      end
   end

   // state and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q         <= ST_IDLE;
         tgt_q         <= TGT_F;
         acc_q         <= '0;
         cnt_q         <= '0;
         tmr_q         <= TMR_LOAD;
         disc_code_q   <= ERR_NONE;
         state_freq_q  <= FREQ_W'(RST_FREQ);
         state_amp_q   <= AMP_W'(RST_AMP);
         state_phase_q <= PHASE_W'(RST_PHASE);
         state_q       <= STATE_W'(RST_STATE);
         upd_q         <= 4'b0000;
         err_q         <= 1'b0;
         err_code_q    <= ERR_NONE;
      end else begin
         fsm_q         <= fsm_d;
         tgt_q         <= tgt_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         tmr_q         <= tmr_d;
         disc_code_q   <= disc_code_d;
         state_freq_q  <= state_freq_d;
         state_amp_q   <= state_amp_d;
         state_phase_q <= state_phase_d;
         state_q       <= state_d;
         upd_q         <= upd_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
      end
   end

   assign state       = state_q;
   assign state_freq  = state_freq_q;
   assign state_amp   = state_amp_q;
   assign state_phase = state_phase_q;
   assign upd         = upd_q;
   assign err         = err_q;
   assign err_code    = err_code_q;

endmodule

// File: doc/awg_cmd_parser.md
Name: awg_cmd_parser

Overview:
- Parametrised UART command parser for the AWG. Replaces the single-field digit shifter.
- Accepts ASCII bytes strobed by the UART receiver and decodes the lettered commands F (frequency), A (amplitude), P (phase) and W (waveform state), each followed by decimal digits and a terminator.
- Range-checks each value and commits it to registered control outputs for the DDS/waveform path.
- Adds strobe synchronisation, range checking, an inter-character timeout and error reporting.

Parameters:
- FREQ_W, 12, width of freq output.
- AMP_W, 3, width of amp output.
- PHASE_W, 8, width of phase output.
- STATE_W, 3, width of wave state output.
- MAX_DIGITS, 5, maximum decimal digits per command.
- TIMEOUT_CYC, 50_000_000, idle clk cycles allowed between bytes of one command.
- RST_FREQ, 1; RST_AMP, 2; RST_PHASE, 50; RST_STATE, 0: output reset values.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd  in  8  ASCII byte from UART receiver; stable while rd high
- rd  in  1  byte-ready strobe, asynchronous to clk, high at least 3 clk cycles
- state  out  STATE_W  waveform select
- state_freq  out  FREQ_W  frequency word
- state_amp  out  AMP_W  amplitude step
- state_phase  out  PHASE_W  phase offset
- upd  out  4  one-cycle commit pulse {W,P,A,F}, bit 0 = F
- err  out  1  one-cycle error pulse
- err_code  out  2  1 = range, 2 = format/too many digits, 3 = timeout; holds last code

Behaviour:
- Reset (rst_n low at a clk edge):
  - outputs take their RST_* values; upd = 0, err = 0, err_code = 0
  - FSM goes to IDLE; accumulator, digit count and timer clear
  - reset mid-command discards the partial command with no commit and no err
- Strobe path: rd passes through a 2-FF synchroniser, then rising-edge detection. A byte is consumed in the cycle the edge is detected, 3 clk cycles after rd rises. cmd is sampled in that cycle.
- Commands:
  - 'F'/'f' selects freq, 'A'/'a' amp, 'P'/'p' phase, 'W'/'w' state.
  - Digits are '0'..'9' (0x30..0x39); '0' is a valid digit.
  - Terminators are CR (0x0D) and LF (0x0A).
- FSM states:
  - IDLE:
    - command letter: latch target, clear acc and count, go to DIGITS
    - any other byte, including terminators: ignored, stay in IDLE
  - DIGITS:
    - digit: acc <= acc*10 + (cmd - 0x30); count++
    - digit arriving when count == MAX_DIGITS: go to DISCARD with code 2
    - terminator with count == 0: err, code 2, go to IDLE
    - terminator with count > 0 and acc <= 2^W - 1 of the target: commit, go to IDLE
    - terminator with count > 0 and acc out of range: err, code 1, no commit, go to IDLE
    - command letter: restart with the new target; no error
    - any other byte: go to DISCARD with code 2
  - DISCARD:
    - all bytes are ignored until a terminator
    - at the terminator, pulse err with the stored code and go to IDLE
- Accumulator:
  - ACC_W = clog2(10^MAX_DIGITS) bits, unsigned
  - multiply as (acc<<3) + (acc<<1); this cannot overflow within MAX_DIGITS
- Commit timing: a terminator consumed in cycle T updates the target output at the T+1 edge. The upd bit is high in cycle T+1 only, coincident with the new value. Untargeted outputs hold.
- Error timing: err is high for one cycle at T+1; err_code updates in the same cycle.
- Timeout:
  - timer counts while in DIGITS or DISCARD and clears on every consumed byte
  - reaching TIMEOUT_CYC-1: err, code 3, go to IDLE, no commit
- Simultaneous events: a consumed byte in the same cycle the timer expires takes priority; the timer clears and the byte is processed.
- Back-to-back commands on one line (for example "F100\nA3\n") each commit independently.

Decomposition:
- Package awg_cmd_pkg holds:
  - ASCII constants for the letters, digit bounds, CR and LF
  - FSM state encoding (IDLE, DIGITS, DISCARD)
  - target encoding (F, A, P, W)
  - error code constants
- Sub-module strobe_sync: 2-FF synchroniser plus rising-edge detector, with ports clk, rst_n, async_in, pulse_out. Reused for other asynchronous strobes.

Test Plan:
- Reset: hold rst_n low 2 cycles, then release -> state_freq = 1, state_amp = 2, state_phase = 50, state = 0, upd = 0, err = 0.
- Send "F1234\n" -> state_freq = 1234 at 1 cycle after the LF byte; upd = 4'b0001 for 1 cycle; other outputs unchanged.
- Send "A9\r" with AMP_W = 3 -> err pulse, err_code = 1, state_amp stays 2; then send "P0\n" -> state_phase = 0, upd = 4'b0100.
- Send "F123456\n" with MAX_DIGITS = 5 -> err, code 2, state_freq unchanged; then send "W7x\n" -> err, code 2, state unchanged.
- Send "F12" and wait TIMEOUT_CYC cycles (use 100 in sim) -> err, code 3, FSM in IDLE; then send "\n" -> no err, no upd.
- Send "PF50\n" -> state_freq = 50, state_phase unchanged. Separately, assert rst_n low after "F9" and then send "\n" -> no commit, no err.
